// File: rtl/iot_pkg.sv
// Shared widths, filter function codes and byte-select helper for the IOTDF feeder.
package iot_pkg;

   localparam int IOT_WORD_W         = 128;
   localparam int IOT_BYTE_W         = 8;
   localparam int IOT_BYTES_PER_WORD = 16;
   localparam int IOT_FN_W           = 3;

   typedef enum logic [IOT_FN_W-1:0] {
      FN_NONE     = 3'd0,
      FN_MAX      = 3'd1,
      FN_MIN      = 3'd2,
      FN_AVG      = 3'd3,
      FN_EXTRACT  = 3'd4,
      FN_EXCLUDE  = 3'd5,
      FN_PEAKMAX  = 3'd6,
      FN_PEAKMIN  = 3'd7
   } iot_fn_e;

   // Byte idx counts from the MSB end: idx 0 is bits 127:120, so base = (15-idx)*8.
   function automatic logic [IOT_BYTE_W-1:0] word_byte(
      input logic [IOT_WORD_W-1:0] word,
      input logic [3:0]            idx
   );
      logic [6:0] base;
      base = {~idx, 3'b000};
      return word[base +: IOT_BYTE_W];
   endfunction

endpackage

// File: rtl/iot_word_fifo.sv
// DEPTH x 128-bit circular word buffer with registered full/empty flags.
module iot_word_fifo
   import iot_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [IOT_WORD_W-1:0] wr_data,
   output logic [IOT_WORD_W-1:0] head,
   output logic                  full,
   output logic                  empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [IOT_WORD_W-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic [CW-1:0]         count_nx;
   logic                  do_push;
   logic                  do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_comb begin
      count_nx = count;
      if (do_push && !do_pop) begin
         count_nx = count + 1'b1;
      end else if (do_pop && !do_push) begin
         count_nx = count - 1'b1;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count_nx;
         full  <= (count_nx == CW'(DEPTH));
         empty <= (count_nx == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/iot_byte_serializer.sv
// Streams buffered 128-bit words to the IOTDF as 16 MSB-first bytes under busy back-pressure.
// Define IOT_SER_DONE_EN to stop after NUM_WORDS words and raise a sticky done.
module iot_byte_serializer
   import iot_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int NUM_WORDS = 96
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [IOT_WORD_W-1:0] in_word,
   input  logic [IOT_FN_W-1:0]   cfg_fn,
   input  logic                  busy,
   output logic                  out_en,
   output logic [IOT_BYTE_W-1:0] out_byte,
   output logic [IOT_FN_W-1:0]   fn_sel,
   output logic                  done
);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || NUM_WORDS < 1 || NUM_WORDS > 128) begin : g_bad_param
      $error("iot_byte_serializer: DEPTH must be a power of two >= 2, NUM_WORDS 1..128");
   end

   logic [IOT_WORD_W-1:0] head;
   logic                  full;
   logic                  empty;
   logic [3:0]            byte_idx;
   logic                  halted;
   logic                  issue;
   logic                  push;
   logic                  pop;

   // Upstream handshake: a word transfers at an edge where in_valid && in_ready.
   // in_ready comes only from registered state, so a same-edge pop cannot raise it.
   assign in_ready = !full && !halted;
   assign push     = in_valid && in_ready;
   assign issue    = !empty && !busy && !halted;
   assign pop      = issue && (byte_idx == 4'hF);

   iot_word_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (pop),
      .wr_data (in_word),
      .head    (head),
      .full    (full),
      .empty   (empty)
   );

   // fn_sel only follows cfg_fn on idle word boundaries, so a word never sees it change.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         byte_idx <= '0;
         out_en   <= 1'b0;
         out_byte <= '0;
         fn_sel   <= FN_NONE;
      end else begin
         if (issue) begin
            out_en   <= 1'b1;
            out_byte <= word_byte(head, byte_idx);
            byte_idx <= byte_idx + 1'b1;
         end else begin
            out_en   <= 1'b0;
            out_byte <= '0;
            if (byte_idx == 4'd0) fn_sel <= cfg_fn;
         end
      end
   end

`ifdef IOT_SER_DONE_EN
   localparam logic [6:0] LAST_WORD = 7'(NUM_WORDS - 1);

   logic [6:0] words_sent;
   logic       done_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         words_sent <= '0;
         done_q     <= 1'b0;
      end else if (pop) begin
         words_sent <= words_sent + 1'b1;
         if (words_sent == LAST_WORD) done_q <= 1'b1;
      end
   end

   assign halted = done_q;
   assign done   = done_q;
`else
   assign halted = 1'b0;
   assign done   = 1'b0;
`endif

endmodule
